// File: rtl/ser_req_arbiter_if.sv
// ser_req_arbiter_if: four bank request ports plus the shared valid/ready serializer port
interface ser_req_arbiter_if;
  logic [3:0]   req_valid;
  logic [59:0]  req_pAddress;
  logic [511:0] req_data;
  logic [15:0]  req_return;
  logic [63:0]  req_size;
  logic [3:0]   req_rw;
  logic [15:0]  req_dest;
  logic [3:0]   req_full;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [14:0]  out_pAddress;
  logic [3:0]   out_return;
  logic [15:0]  out_size;
  logic         out_rw;
  logic [3:0]   out_dest;
  logic [1:0]   out_src;
  modport master (
    output req_valid, req_pAddress, req_data, req_return, req_size, req_rw, req_dest, out_ready,
    input  req_full, out_valid, out_data, out_pAddress, out_return, out_size, out_rw, out_dest, out_src
  );
  modport slave (
    input  req_valid, req_pAddress, req_data, req_return, req_size, req_rw, req_dest, out_ready,
    output req_full, out_valid, out_data, out_pAddress, out_return, out_size, out_rw, out_dest, out_src
  );
endinterface

// File: rtl/ser_req_arbiter.sv
// ser_req_arbiter: four one-entry bank slots drained round-robin into a registered valid/ready stage
module ser_req_arbiter (
  input logic clk,
  input logic rst,
  ser_req_arbiter_if.slave bus
);
  typedef struct packed {
    logic [127:0] data;
    logic [14:0]  addr;
    logic [3:0]   ret;
    logic [15:0]  size;
    logic         rw;
    logic [3:0]   dest;
  } req_t;
  req_t in_req [4];
  req_t slot [4];
  req_t out_q;
  logic [3:0] held;
  logic [1:0] rr_ptr, win, out_src_q;
  logic out_valid_q, found, adv, grant;
  always_comb begin
    for (int i = 0; i < 4; i++)
      in_req[i] = '{data: bus.req_data[128*i +: 128], addr: bus.req_pAddress[15*i +: 15],
                    ret: bus.req_return[4*i +: 4], size: bus.req_size[16*i +: 16],
                    rw: bus.req_rw[i], dest: bus.req_dest[4*i +: 4]};
  end
  // scan from the farthest offset down so the slot nearest rr_ptr overrides
  always_comb begin
    win = rr_ptr;
    found = 1'b0;
    for (int k = 3; k >= 0; k--)
      if (held[rr_ptr + 2'(k)]) begin
        win = rr_ptr + 2'(k);
        found = 1'b1;
      end
  end
  assign adv = !out_valid_q || bus.out_ready;
  assign grant = adv && found;
  // a slot granted on this edge was HELD, so it cannot also capture here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held <= '0;
      rr_ptr <= '0;
      out_valid_q <= 1'b0;
      out_src_q <= '0;
      out_q <= '0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (!held[i] && bus.req_valid[i]) begin
          held[i] <= 1'b1;
          slot[i] <= in_req[i];
        end else if (grant && win == 2'(i)) held[i] <= 1'b0;
      if (adv) out_valid_q <= found;
      if (grant) begin
        out_q <= slot[win];
        out_src_q <= win;
        rr_ptr <= win + 2'd1;
      end
    end
  end
  assign bus.req_full = held;
  assign bus.out_valid = out_valid_q;
  assign bus.out_src = out_src_q;
  assign bus.out_data = out_q.data;
  assign bus.out_pAddress = out_q.addr;
  assign bus.out_return = out_q.ret;
  assign bus.out_size = out_q.size;
  assign bus.out_rw = out_q.rw;
  assign bus.out_dest = out_q.dest;
endmodule

// File: tb/tb_ser_req_arbiter.sv
// tb_ser_req_arbiter: directed scenarios plus random traffic against a slot/queue reference model
module tb_ser_req_arbiter;
  typedef struct packed {
    logic [127:0] data;
    logic [14:0]  addr;
    logic [3:0]   ret;
    logic [15:0]  size;
    logic         rw;
    logic [3:0]   dest;
  } fld_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  ser_req_arbiter_if bus ();
  ser_req_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  bit   m_held [4];
  fld_t m_f [4];
  bit   m_ov;
  fld_t m_out;
  int   m_src, m_rr;
  fld_t f, fa;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic fld_t rand_fld();
    fld_t r;
    r.data = {$urandom, $urandom, $urandom, $urandom};
    r.addr = 15'($urandom);
    r.ret = 4'($urandom);
    r.size = 16'(1) << $urandom_range(15);
    r.rw = 1'($urandom);
    r.dest = 4'($urandom);
    return r;
  endfunction

  function automatic fld_t get_in(int i);
    fld_t r;
    r.data = bus.req_data[128*i +: 128];
    r.addr = bus.req_pAddress[15*i +: 15];
    r.ret = bus.req_return[4*i +: 4];
    r.size = bus.req_size[16*i +: 16];
    r.rw = bus.req_rw[i];
    r.dest = bus.req_dest[4*i +: 4];
    return r;
  endfunction

  task automatic set_bank(int i, fld_t v);
    bus.req_data[128*i +: 128] = v.data;
    bus.req_pAddress[15*i +: 15] = v.addr;
    bus.req_return[4*i +: 4] = v.ret;
    bus.req_size[16*i +: 16] = v.size;
    bus.req_rw[i] = v.rw;
    bus.req_dest[4*i +: 4] = v.dest;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_held[i] = 1'b0;
      m_f[i] = '0;
    end
    m_ov = 1'b0;
    m_out = '0;
    m_src = 0;
    m_rr = 0;
  endfunction

  // one clock edge: grant decided from pre-edge occupancy, captures only into slots empty before the edge
  function automatic void model_edge();
    bit adv;
    bit cap [4];
    int w;
    adv = !m_ov || bus.out_ready;
    w = -1;
    for (int i = 0; i < 4; i++) cap[i] = bus.req_valid[i] && !m_held[i];
    for (int off = 0; off < 4; off++)
      if (w < 0 && m_held[(m_rr + off) % 4]) w = (m_rr + off) % 4;
    if (adv) begin
      if (w >= 0) begin
        m_ov = 1'b1;
        m_out = m_f[w];
        m_src = w;
        m_rr = (w + 1) % 4;
        m_held[w] = 1'b0;
      end else m_ov = 1'b0;
    end
    for (int i = 0; i < 4; i++)
      if (cap[i]) begin
        m_held[i] = 1'b1;
        m_f[i] = get_in(i);
      end
  endfunction

  task automatic check_all();
    logic [3:0] full;
    for (int i = 0; i < 4; i++) full[i] = m_held[i];
    chk("req_full", 128'(bus.req_full), 128'(full));
    chk("out_valid", 128'(bus.out_valid), 128'(m_ov));
    chk("out_src", 128'(bus.out_src), 128'(m_src));
    chk("out_data", bus.out_data, m_out.data);
    chk("out_pAddress", 128'(bus.out_pAddress), 128'(m_out.addr));
    chk("out_return", 128'(bus.out_return), 128'(m_out.ret));
    chk("out_size", 128'(bus.out_size), 128'(m_out.size));
    chk("out_rw", 128'(bus.out_rw), 128'(m_out.rw));
    chk("out_dest", 128'(bus.out_dest), 128'(m_out.dest));
    chk("rr_ptr", 128'(dut.rr_ptr), 128'(m_rr));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_pAddress = '0;
    bus.req_data = '0;
    bus.req_return = '0;
    bus.req_size = '0;
    bus.req_rw = '0;
    bus.req_dest = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_full", 128'(bus.req_full), 128'(0));
    chk("rst_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_data", bus.out_data, 128'(0));
    // single request
    bus.out_ready = 1'b1;
    f = rand_fld();
    f.addr = 15'h1A2B;
    f.rw = 1'b0;
    set_bank(0, f);
    bus.req_valid = 4'b0001;
    step();
    chk("t1_full", 128'(bus.req_full), 128'(4'b0001));
    bus.req_valid = '0;
    step();
    chk("t1_valid", 128'(bus.out_valid), 128'(1));
    chk("t1_addr", 128'(bus.out_pAddress), 128'(15'h1A2B));
    chk("t1_src", 128'(bus.out_src), 128'(0));
    chk("t1_full0", 128'(bus.req_full), 128'(0));
    // all four at once
    do_reset();
    for (int i = 0; i < 4; i++) set_bank(i, rand_fld());
    bus.req_valid = 4'hF;
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_src", 128'(bus.out_src), 128'(i));
    end
    chk("t2_rr", 128'(dut.rr_ptr), 128'(0));
    // back-pressure with slots 1 and 2 held behind bank 1 in the output stage
    do_reset();
    bus.out_ready = 1'b0;
    fa = rand_fld();
    set_bank(1, fa);
    set_bank(2, rand_fld());
    bus.req_valid = 4'b0110;
    step();
    bus.req_valid = '0;
    step();
    set_bank(1, rand_fld());
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_src", 128'(bus.out_src), 128'(1));
      chk("t3_full", 128'(bus.req_full), 128'(4'b0110));
      chk("t3_data", bus.out_data, fa.data);
    end
    bus.out_ready = 1'b1;
    step();
    chk("t3_next", 128'(bus.out_src), 128'(2));
    // wrap-around
    do_reset();
    set_bank(3, rand_fld());
    bus.req_valid = 4'b1000;
    step();
    bus.req_valid = '0;
    step();
    chk("t4_src3", 128'(bus.out_src), 128'(3));
    set_bank(0, rand_fld());
    set_bank(3, rand_fld());
    bus.req_valid = 4'b1001;
    step();
    bus.req_valid = '0;
    step();
    chk("t4_src0", 128'(bus.out_src), 128'(0));
    step();
    chk("t4_src3b", 128'(bus.out_src), 128'(3));
    // violation and grant-edge refill
    do_reset();
    bus.out_ready = 1'b0;
    set_bank(0, rand_fld());
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    step();
    f = rand_fld();
    f.data = {16{8'hAA}};
    set_bank(2, f);
    bus.req_valid = 4'b0100;
    step();
    f.data = {16{8'h55}};
    set_bank(2, f);
    step();
    chk("t5_full", 128'(bus.req_full), 128'(4'b0100));
    bus.out_ready = 1'b1;
    step();
    chk("t5_keep", bus.out_data, {16{8'hAA}});
    chk("t5_src", 128'(bus.out_src), 128'(2));
    chk("t5_noref", 128'(bus.req_full), 128'(0));
    f.data = {16{8'h33}};
    set_bank(2, f);
    step();
    chk("t5_ref", 128'(bus.req_full), 128'(4'b0100));
    bus.req_valid = '0;
    step();
    chk("t5_new", bus.out_data, {16{8'h33}});
    // asynchronous reset mid-burst
    do_reset();
    bus.out_ready = 1'b0;
    set_bank(0, rand_fld());
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    step();
    for (int i = 1; i < 4; i++) set_bank(i, rand_fld());
    bus.req_valid = 4'b1110;
    step();
    bus.req_valid = '0;
    chk("t6_pre_full", 128'(bus.req_full), 128'(4'b1110));
    chk("t6_pre_valid", 128'(bus.out_valid), 128'(1));
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("t6_full", 128'(bus.req_full), 128'(0));
    chk("t6_valid", 128'(bus.out_valid), 128'(0));
    chk("t6_rr", 128'(dut.rr_ptr), 128'(0));
    @(negedge clk);
    check_all();
    rst = 1'b1;
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) set_bank(i, rand_fld());
      bus.req_valid = 4'($urandom);
      bus.out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(199) == 0) do_reset();
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
